// File: rtl/pipeline_sequencer.sv
// Run/step/halt controller for the 5-stage pipeline: stage enables/flushes plus cycle and stall counters.
// Optional watchdog on RUN length is compiled in with PIPE_WATCHDOG_EN.
module pipeline_sequencer #(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] WDOG_LIMIT = 32'hFFFF_FFFF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall_req,
  input  logic             i_flush_req,
  input  logic             i_halt_wb,
  input  logic             i_dbg_run,
  input  logic             i_dbg_step,
  input  logic             i_dbg_halt,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_en,
  output logic             o_idex_flush,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic [1:0]       o_state,
  output logic             o_step_done,
  output logic             o_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             step_done_q, step_done_d;
  logic             advance;
  logic             wdog_hit;

  assign advance = (state_q == S_RUN) || (state_q == S_STEP);

  // Stall beats flush: the branch is still in ID and re-resolves next cycle.
  assign o_pc_en      = advance & ~i_stall_req;
  assign o_ifid_en    = advance & ~i_stall_req;
  assign o_ifid_flush = advance & i_flush_req & ~i_stall_req;
  assign o_idex_en    = advance;
  assign o_idex_flush = advance & i_stall_req;
  assign o_exmem_en   = advance;
  assign o_memwb_en   = advance;

`ifdef PIPE_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 32'd1);
  logic timeout_q;

  assign wdog_hit  = (state_q == S_RUN) && (cycle_q == WDOG_LAST);
  assign o_timeout = timeout_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)         timeout_q <= 1'b0;
    else if (wdog_hit) timeout_q <= 1'b1;
  end
`else
  assign wdog_hit  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_dbg_halt)      state_d = S_IDLE;
        else if (i_dbg_step) state_d = S_STEP;
        else if (i_dbg_run)  state_d = S_RUN;
      end
      S_RUN: begin
        if (i_halt_wb || wdog_hit) state_d = S_DONE;
        else if (i_dbg_halt)       state_d = S_IDLE;
      end
      S_STEP: begin
        step_done_d = 1'b1;
        state_d     = i_halt_wb ? S_DONE : S_IDLE;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters saturate rather than wrap so the debug unit never sees a rollback.
  always_comb begin
    cycle_d = cycle_q;
    stall_d = stall_q;
    if (advance) begin
      if (cycle_q != '1)                stall_d = stall_q;
      if (cycle_q != '1)                cycle_d = cycle_q + 1'b1;
      if (i_stall_req && stall_q != '1) stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cycle_q     <= '0;
      stall_q     <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      stall_q     <= stall_d;
      step_done_q <= step_done_d;
    end
  end

  assign o_state     = state_q;
  assign o_done      = (state_q == S_DONE);
  assign o_step_done = step_done_q;
  assign o_cycle_cnt = cycle_q;
  assign o_stall_cnt = stall_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: reset, step, stall/flush, command priority, DONE, reset-in-STEP, watchdog.
module tb_pipeline_sequencer;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst, stall, flush, halt_wb, dbg_run, dbg_step, dbg_halt;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
  logic [1:0]       state;
  logic             step_done, done, timeout;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_sequencer #(.CNT_W(CNT_W), .WDOG_LIMIT(32'd8)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall_req(stall), .i_flush_req(flush),
    .i_halt_wb(halt_wb), .i_dbg_run(dbg_run), .i_dbg_step(dbg_step), .i_dbg_halt(dbg_halt),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush),
    .o_idex_en(idex_en), .o_idex_flush(idex_flush), .o_exmem_en(exmem_en),
    .o_memwb_en(memwb_en), .o_state(state), .o_step_done(step_done), .o_done(done),
    .o_timeout(timeout), .o_cycle_cnt(cycle_cnt), .o_stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; halt_wb = 0; dbg_run = 0; dbg_step = 0; dbg_halt = 0;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_pc_en", 32'(pc_en), 32'h0);
    chk("rst_idex_en", 32'(idex_en), 32'h0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_step_done", 32'(step_done), 32'h0);
    stall = 1; flush = 1; #1;
    chk("idle_idex_flush", 32'(idex_flush), 32'h0);
    chk("idle_ifid_flush", 32'(ifid_flush), 32'h0);
    stall = 0; flush = 0;

    // single step
    dbg_step = 1; tick(); dbg_step = 0;
    chk("step_state", 32'(state), 32'h2);
    chk("step_pc_en", 32'(pc_en), 32'h1);
    chk("step_memwb_en", 32'(memwb_en), 32'h1);
    tick();
    chk("step_back_idle", 32'(state), 32'h0);
    chk("step_cycle", cycle_cnt, 32'd1);
    chk("step_done_pulse", 32'(step_done), 32'h1);
    tick();
    chk("step_done_clear", 32'(step_done), 32'h0);

    // run with a two-cycle stall
    dbg_run = 1; tick(); dbg_run = 0;
    chk("run_state", 32'(state), 32'h1);
    stall = 1; #1;
    chk("stall_pc_en", 32'(pc_en), 32'h0);
    chk("stall_ifid_en", 32'(ifid_en), 32'h0);
    chk("stall_idex_flush", 32'(idex_flush), 32'h1);
    chk("stall_exmem_en", 32'(exmem_en), 32'h1);
    chk("stall_memwb_en", 32'(memwb_en), 32'h1);
    tick(); tick();
    stall = 0; #1;
    chk("stall_cnt2", stall_cnt, 32'd2);
    chk("cycle_cnt3", cycle_cnt, 32'd3);
    chk("unstall_pc_en", 32'(pc_en), 32'h1);
    chk("unstall_idex_flush", 32'(idex_flush), 32'h0);

    // flush alone, then flush with stall
    flush = 1; #1;
    chk("flush_ifid", 32'(ifid_flush), 32'h1);
    chk("flush_idex", 32'(idex_flush), 32'h0);
    stall = 1; #1;
    chk("flushstall_ifid", 32'(ifid_flush), 32'h0);
    chk("flushstall_idex", 32'(idex_flush), 32'h1);
    flush = 0; stall = 0;

    // halt beats step
    dbg_halt = 1; dbg_step = 1; tick(); dbg_halt = 0; dbg_step = 0;
    chk("halt_wins_state", 32'(state), 32'h0);
    chk("halt_cycle", cycle_cnt, 32'd4);
    chk("halt_pc_en", 32'(pc_en), 32'h0);

    // run then HALT in WB
    dbg_run = 1; tick(); dbg_run = 0;
    chk("rerun_state", 32'(state), 32'h1);
    halt_wb = 1; tick(); halt_wb = 0;
    chk("done_state", 32'(state), 32'h3);
    chk("done_flag", 32'(done), 32'h1);
    chk("done_pc_en", 32'(pc_en), 32'h0);
    chk("done_cycle", cycle_cnt, 32'd5);
    dbg_run = 1; dbg_step = 1; tick(); tick(); dbg_run = 0; dbg_step = 0;
    chk("done_absorb", 32'(state), 32'h3);
    chk("done_frozen", cycle_cnt, 32'd5);
    chk("done_no_timeout", 32'(timeout), 32'h0);

    // reset inside the STEP cycle
    rst = 1; tick(); rst = 0;
    chk("rst2_state", 32'(state), 32'h0);
    dbg_step = 1; tick(); dbg_step = 0;
    chk("step2_state", 32'(state), 32'h2);
    rst = 1; tick(); rst = 0;
    chk("rst_step_state", 32'(state), 32'h0);
    chk("rst_step_cycle", cycle_cnt, 32'd0);
    chk("rst_step_done", 32'(step_done), 32'h0);
    tick();
    chk("rst_step_done2", 32'(step_done), 32'h0);

    // watchdog window of 8 advance cycles
    dbg_run = 1; tick(); dbg_run = 0;
    chk("wd_run", 32'(state), 32'h1);
    repeat (8) tick();
    chk("wd_cycle", cycle_cnt, 32'd8);
`ifdef PIPE_WATCHDOG_EN
    chk("wd_state", 32'(state), 32'h3);
    chk("wd_timeout", 32'(timeout), 32'h1);
`else
    chk("wd_state", 32'(state), 32'h1);
    chk("wd_timeout", 32'(timeout), 32'h0);
`endif

    // step that retires HALT goes to DONE and still pulses step_done
    rst = 1; tick(); rst = 0;
    chk("wd_rst_timeout", 32'(timeout), 32'h0);
    dbg_step = 1; tick(); dbg_step = 0;
    halt_wb = 1; tick(); halt_wb = 0;
    chk("stephalt_state", 32'(state), 32'h3);
    chk("stephalt_done", 32'(step_done), 32'h1);
    chk("stephalt_cycle", cycle_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
